// File: rtl/hcsr04_ranger_if.sv
// Scheduler/sensor-side signal bundle of the HC-SR04 ranger.
interface hcsr04_ranger_if;
    logic       start;
    logic       echo;
    logic       trig;
    logic       done;
    logic       busy;
    logic [8:0] dist_cm;
    logic       dist_valid;
    logic       timeout;

    modport master (
        output start, echo,
        input  trig, done, busy, dist_cm, dist_valid, timeout
    );

    modport slave (
        input  start, echo,
        output trig, done, busy, dist_cm, dist_valid, timeout
    );
endinterface

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: trigger pulse, echo timing, distance in cm with timeout.
// Optional echo deglitch filter enabled by defining HCSR04_ECHO_DEGLITCH_EN.
module hcsr04_ranger #(
    parameter int unsigned CLK_HZ     = 32'd50_000_000,
    parameter int unsigned TRIG_US    = 32'd10,
    parameter int unsigned TIMEOUT_US = 32'd30000,
    parameter int unsigned US_PER_CM  = 32'd58
) (
    input  logic           clk,
    input  logic           rst,
    hcsr04_ranger_if.slave bus
);
    localparam longint unsigned TRIG_CLKS_L = (64'(TRIG_US) * 64'(CLK_HZ)) / 64'd1_000_000;
    localparam longint unsigned CM_CLKS_L   = (64'(US_PER_CM) * 64'(CLK_HZ)) / 64'd1_000_000;
    localparam longint unsigned TMO_CLKS_L  = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1_000_000;
    localparam int unsigned TRIG_CLKS = 32'(TRIG_CLKS_L);
    localparam int unsigned CM_CLKS   = 32'(CM_CLKS_L);
    localparam int unsigned TMO_CLKS  = 32'(TMO_CLKS_L);
    localparam int TRIG_W = $clog2(TRIG_CLKS + 32'd1);
    localparam int CM_W   = $clog2(CM_CLKS + 32'd1);
    localparam int TMO_W  = $clog2(TMO_CLKS + 32'd1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            state_q;
    logic              echo_s1_q, echo_s2_q, echo_prev_q;
    logic              echo_f_s, echo_rise_s, echo_fall_s;
    logic [TRIG_W-1:0] trig_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [CM_W-1:0]   pre_q, pre_d;
    logic [8:0]        dist_q, dist_d;
    logic              trig_q, done_q, busy_q, dist_valid_q, timeout_q;
    logic [8:0]        dist_cm_q;

    // Two-flop synchronizer for the asynchronous echo input
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
        end else begin
            echo_s1_q <= bus.echo;
            echo_s2_q <= echo_s1_q;
        end
    end

`ifdef HCSR04_ECHO_DEGLITCH_EN
    logic       echo_f_q;
    logic [2:0] dg_cnt_q;

    // Level must persist 8 consecutive clks before echo_f follows it
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_f_q <= 1'b0;
            dg_cnt_q <= 3'd0;
        end else if (echo_s2_q != echo_f_q) begin
            if (dg_cnt_q == 3'd7) begin
                echo_f_q <= echo_s2_q;
                dg_cnt_q <= 3'd0;
            end else begin
                dg_cnt_q <= dg_cnt_q + 3'd1;
            end
        end else begin
            dg_cnt_q <= 3'd0;
        end
    end

    assign echo_f_s = echo_f_q;
`else
    assign echo_f_s = echo_s2_q;
`endif

    assign echo_rise_s = echo_f_s & ~echo_prev_q;
    assign echo_fall_s = ~echo_f_s & echo_prev_q;

    // Distance prescaler: one cm per CM_CLKS high clks, saturating at 511
    always_comb begin
        pre_d  = pre_q + CM_W'(1);
        dist_d = dist_q;
        if (pre_q == CM_W'(CM_CLKS - 32'd1)) begin
            pre_d = {CM_W{1'b0}};
            if (dist_q != 9'd511) begin
                dist_d = dist_q + 9'd1;
            end else begin
                dist_d = dist_q;
            end
        end else begin
            dist_d = dist_q;
        end
    end

    // Measurement FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            echo_prev_q  <= 1'b0;
            trig_cnt_q   <= {TRIG_W{1'b0}};
            tmo_cnt_q    <= {TMO_W{1'b0}};
            pre_q        <= {CM_W{1'b0}};
            dist_q       <= 9'd0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            dist_cm_q    <= 9'd0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            echo_prev_q <= echo_f_s;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q    <= S_TRIG;
                        trig_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        trig_cnt_q <= {TRIG_W{1'b0}};
                    end
                end
                S_TRIG: begin
                    if (trig_cnt_q == TRIG_W'(TRIG_CLKS - 32'd1)) begin
                        state_q   <= S_WAIT_RISE;
                        trig_q    <= 1'b0;
                        tmo_cnt_q <= {TMO_W{1'b0}};
                        pre_q     <= {CM_W{1'b0}};
                        dist_q    <= 9'd0;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + TRIG_W'(1);
                    end
                end
                // A rise on the expiry clk cannot complete, so expiry wins here
                S_WAIT_RISE: begin
                    if (tmo_cnt_q == TMO_W'(TMO_CLKS - 32'd1)) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        dist_valid_q <= 1'b0;
                        timeout_q    <= 1'b1;
                    end else if (echo_rise_s) begin
                        state_q   <= S_MEASURE;
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        pre_q     <= pre_d;
                        dist_q    <= dist_d;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (echo_fall_s) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        dist_cm_q    <= dist_q;
                        dist_valid_q <= 1'b1;
                        timeout_q    <= 1'b0;
                    end else if (tmo_cnt_q == TMO_W'(TMO_CLKS - 32'd1)) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        dist_valid_q <= 1'b0;
                        timeout_q    <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        pre_q     <= pre_d;
                        dist_q    <= dist_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    trig_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig       = trig_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.dist_cm    = dist_cm_q;
    assign bus.dist_valid = dist_valid_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger, scaled to 1 clk per us (trig 10, cm 58, timeout 3000 clks).
module tb_hcsr04_ranger;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   trig_rises = 0;
    int   trig_run = 0;
    int   trig_len = 0;
    int   done_cnt = 0;
    bit   trig_prev = 1'b0;

`ifdef HCSR04_ECHO_DEGLITCH_EN
    localparam int FALL_LAT = 11;
`else
    localparam int FALL_LAT = 3;
`endif

    hcsr04_ranger_if vif ();

    hcsr04_ranger #(
        .CLK_HZ    (32'd1_000_000),
        .TRIG_US   (32'd10),
        .TIMEOUT_US(32'd3000),
        .US_PER_CM (32'd58)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge
    always @(negedge clk) begin
        trig_prev <= vif.trig;
        if (vif.trig && !trig_prev) begin
            trig_rises <= trig_rises + 1;
            trig_run   <= 1;
        end else if (vif.trig) begin
            trig_run <= trig_run + 1;
        end
        if (!vif.trig && trig_prev) trig_len <= trig_run;
        if (vif.done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        vif.start = 1'b1;
        tick(1);
        vif.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            lat++;
            if (vif.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_meas(input int pre, input int high, output int lat, output bit ok);
        pulse_start();
        tick(10);
        tick(pre);
        vif.echo = 1'b1;
        tick(high);
        vif.echo = 1'b0;
        wait_done(3500, lat, ok);
    endtask

    initial begin
        int lat;
        bit ok;
        int d0, t0;

        rst = 1'b1;
        vif.start = 1'b0;
        vif.echo  = 1'b0;
        tick(3);
        chk("rst_trig", 32'(vif.trig), 32'd0);
        chk("rst_done", 32'(vif.done), 32'd0);
        chk("rst_busy", 32'(vif.busy), 32'd0);
        chk("rst_dist", 32'(vif.dist_cm), 32'd0);
        chk("rst_valid", 32'(vif.dist_valid), 32'd0);
        chk("rst_timeout", 32'(vif.timeout), 32'd0);
        rst = 1'b0;
        tick(2);

        // 1160 us echo, 200 us after trig fall -> 20 cm
        pulse_start();
        chk("A_trig_hi", 32'(vif.trig), 32'd1);
        chk("A_busy_hi", 32'(vif.busy), 32'd1);
        tick(10);
        chk("A_trig_lo", 32'(vif.trig), 32'd0);
        chk("A_busy_wait", 32'(vif.busy), 32'd1);
        tick(200);
        vif.echo = 1'b1;
        tick(1160);
        vif.echo = 1'b0;
        wait_done(3500, lat, ok);
        chk("A_done_seen", 32'(ok), 32'd1);
        chk("A_fall_lat", 32'(lat), 32'(FALL_LAT));
        chk("A_dist", 32'(vif.dist_cm), 32'd20);
        chk("A_valid", 32'(vif.dist_valid), 32'd1);
        chk("A_timeout", 32'(vif.timeout), 32'd0);
        chk("A_busy_done", 32'(vif.busy), 32'd1);
        tick(1);
        chk("A_done_1clk", 32'(vif.done), 32'd0);
        chk("A_busy_idle", 32'(vif.busy), 32'd0);
        tick(20);
        chk("A_dist_hold", 32'(vif.dist_cm), 32'd20);
        chk("A_trig_len", 32'(trig_len), 32'd10);

        // No echo -> timeout exactly 3000 clks after WAIT_RISE entry
        pulse_start();
        tick(10);
        wait_done(3500, lat, ok);
        chk("B_done_seen", 32'(ok), 32'd1);
        chk("B_tmo_lat", 32'(lat), 32'd3000);
        chk("B_timeout", 32'(vif.timeout), 32'd1);
        chk("B_valid", 32'(vif.dist_valid), 32'd0);
        chk("B_dist_hold", 32'(vif.dist_cm), 32'd20);
        tick(5);

        // Second start 100 clks in is ignored
        d0 = done_cnt;
        t0 = trig_rises;
        pulse_start();
        tick(99);
        pulse_start();
        tick(50);
        vif.echo = 1'b1;
        tick(580);
        vif.echo = 1'b0;
        wait_done(3500, lat, ok);
        chk("C_done_seen", 32'(ok), 32'd1);
        chk("C_dist", 32'(vif.dist_cm), 32'd10);
        chk("C_timeout", 32'(vif.timeout), 32'd0);
        tick(30);
        chk("C_one_done", 32'(done_cnt - d0), 32'd1);
        chk("C_one_trig", 32'(trig_rises - t0), 32'd1);
        chk("C_idle", 32'(vif.busy), 32'd0);

        // Echo already high through TRIG is ignored; later 580 us pulse -> 10 cm
        vif.echo = 1'b1;
        tick(20);
        pulse_start();
        tick(10);
        tick(50);
        vif.echo = 1'b0;
        tick(100);
        vif.echo = 1'b1;
        tick(580);
        vif.echo = 1'b0;
        wait_done(3500, lat, ok);
        chk("D_done_seen", 32'(ok), 32'd1);
        chk("D_dist", 32'(vif.dist_cm), 32'd10);
        chk("D_valid", 32'(vif.dist_valid), 32'd1);
        tick(5);

        // Floor boundaries around 58 clks per cm
        do_meas(30, 57, lat, ok);
        chk("E57_dist", 32'(vif.dist_cm), 32'd0);
        chk("E57_valid", 32'(vif.dist_valid), 32'd1);
        tick(5);
        do_meas(30, 58, lat, ok);
        chk("E58_dist", 32'(vif.dist_cm), 32'd1);
        tick(5);
        do_meas(30, 115, lat, ok);
        chk("E115_dist", 32'(vif.dist_cm), 32'd1);
        tick(5);
        do_meas(30, 116, lat, ok);
        chk("E116_done_seen", 32'(ok), 32'd1);
        chk("E116_dist", 32'(vif.dist_cm), 32'd2);
        tick(5);

        // 3-clk glitch during WAIT_RISE
        do_meas(30, 3, lat, ok);
        chk("G_done_seen", 32'(ok), 32'd1);
`ifdef HCSR04_ECHO_DEGLITCH_EN
        chk("G_timeout", 32'(vif.timeout), 32'd1);
        chk("G_valid", 32'(vif.dist_valid), 32'd0);
        chk("G_dist", 32'(vif.dist_cm), 32'd2);
`else
        chk("G_timeout", 32'(vif.timeout), 32'd0);
        chk("G_valid", 32'(vif.dist_valid), 32'd1);
        chk("G_dist", 32'(vif.dist_cm), 32'd0);
`endif
        tick(5);

        // Reset mid-MEASURE, then a normal measurement
        pulse_start();
        tick(30);
        vif.echo = 1'b1;
        tick(100);
        d0 = done_cnt;
        rst = 1'b1;
        tick(1);
        chk("H_trig", 32'(vif.trig), 32'd0);
        chk("H_busy", 32'(vif.busy), 32'd0);
        chk("H_done", 32'(vif.done), 32'd0);
        chk("H_dist", 32'(vif.dist_cm), 32'd0);
        chk("H_valid", 32'(vif.dist_valid), 32'd0);
        chk("H_timeout", 32'(vif.timeout), 32'd0);
        rst = 1'b0;
        vif.echo = 1'b0;
        tick(40);
        chk("H_no_done", 32'(done_cnt - d0), 32'd0);
        chk("H_still_idle", 32'(vif.busy), 32'd0);
        do_meas(20, 290, lat, ok);
        chk("H_done_seen", 32'(ok), 32'd1);
        chk("H_dist_after", 32'(vif.dist_cm), 32'd5);
        chk("H_valid_after", 32'(vif.dist_valid), 32'd1);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
